// File: rtl/ddr3_ar_issue.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_ar_issue
// Description : Pops packed read commands from the address FIFO and issues
//               them on the DDR3 AXI read-address channel. Throttles the
//               number of in-flight bursts and tracks R-channel completions.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_ar_issue #(
  parameter int FIFO_LAT = 2,  // araddr_ref rising edge -> stable FIFO outputs
  parameter int MAX_OUT  = 4   // max in-flight bursts, 1..15
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        araddr_empty,
  output logic        araddr_ref,
  input  logic [27:0] fifo_araddr,
  input  logic [3:0]  fifo_aruser_id,
  input  logic [3:0]  fifo_arlen,
  output logic [27:0] axi_araddr,
  output logic [3:0]  axi_aruser_id,
  output logic [3:0]  axi_arlen,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic        axi_rvalid,
  input  logic        axi_rlast,
  output logic [3:0]  outstanding,
  output logic        busy,
  output logic        err_underflow
);

  // State encoding
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_pop   = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_latch = 3'd3;
  localparam logic [2:0] c_st_issue = 3'd4;

  // WAIT spends FIFO_LAT-1 cycles; with FIFO_LAT<=1 it is skipped entirely.
  localparam int              c_wait_cyc  = (FIFO_LAT > 1) ? (FIFO_LAT - 1) : 0;
  localparam int              c_cnt_w     = (c_wait_cyc > 1) ? $clog2(c_wait_cyc) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'((c_wait_cyc > 0) ? (c_wait_cyc - 1) : 0);
  localparam logic [3:0]      c_max_out   = 4'(MAX_OUT);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic [3:0]         r_outstanding;
  logic               r_err_underflow;
  logic [27:0]        r_araddr;
  logic [3:0]         r_aruser_id;
  logic [3:0]         r_arlen;

  logic               w_can_issue;
  logic               w_wait_done;
  logic               w_ar_accept;
  logic               w_rlast_beat;
  logic               w_dec;
  logic               w_underflow;

  // The throttle deliberately looks at the registered count, so a completion
  // only unblocks a new pop one cycle after it is seen.
  assign w_can_issue  = enable & ~araddr_empty & (r_outstanding < c_max_out);
  assign w_wait_done  = (r_wait_cnt == c_wait_last);
  assign w_ar_accept  = axi_arvalid & axi_arready;
  assign w_rlast_beat = axi_rvalid & axi_rlast;
  assign w_dec        = w_rlast_beat & (r_outstanding != 4'd0);
  assign w_underflow  = w_rlast_beat & (r_outstanding == 4'd0);

  // State register
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; enable and araddr_empty only matter in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_can_issue) begin
          w_state_nxt = c_st_pop;
        end
      end
      c_st_pop: begin
        w_state_nxt = (c_wait_cyc > 0) ? c_st_wait : c_st_latch;
      end
      c_st_wait: begin
        if (w_wait_done) begin
          w_state_nxt = c_st_latch;
        end
      end
      c_st_latch: begin
        w_state_nxt = c_st_issue;
      end
      c_st_issue: begin
        if (axi_arready) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Outputs decoded from state: one-cycle pop strobe and AR valid
  always_comb begin
    araddr_ref  = 1'b0;
    axi_arvalid = 1'b0;
    case (r_state)
      c_st_pop:   araddr_ref  = 1'b1;
      c_st_issue: axi_arvalid = 1'b1;
      default: begin
        araddr_ref  = 1'b0;
        axi_arvalid = 1'b0;
      end
    endcase
  end

  // FIFO latency counter, restarted on every pop
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_st_pop) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_st_wait) begin
      r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
    end
  end

  // Capture the popped command once the FIFO output has settled; held through ISSUE
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_araddr    <= 28'd0;
      r_aruser_id <= 4'd0;
      r_arlen     <= 4'd0;
    end else if (r_state == c_st_latch) begin
      r_araddr    <= fifo_araddr;
      r_aruser_id <= fifo_aruser_id;
      r_arlen     <= fifo_arlen;
    end
  end

  // In-flight burst count: +1 per AR accept, -1 per RLAST, saturating both ways
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 4'd0;
    end else if (w_ar_accept && !w_dec) begin
      if (r_outstanding != 4'hF) begin
        r_outstanding <= r_outstanding + 4'd1;
      end
    end else if (w_dec && !w_ar_accept) begin
      r_outstanding <= r_outstanding - 4'd1;
    end
  end

  // Sticky flag for an RLAST with nothing in flight
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_err_underflow <= 1'b0;
    end else if (w_underflow) begin
      r_err_underflow <= 1'b1;
    end
  end

  assign axi_araddr    = r_araddr;
  assign axi_aruser_id = r_aruser_id;
  assign axi_arlen     = r_arlen;
  assign outstanding   = r_outstanding;
  assign err_underflow = r_err_underflow;
  assign busy          = (r_state != c_st_idle) | (r_outstanding != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ar_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_ar_issue
// Description : Directed bench for ddr3_ar_issue with a registered-output
//               address FIFO model (two-cycle pop latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_ar_issue;

  logic        clk_100M = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        araddr_empty = 1'b1;
  logic        araddr_ref;
  logic [27:0] fifo_araddr = 28'd0;
  logic [3:0]  fifo_aruser_id = 4'd0;
  logic [3:0]  fifo_arlen = 4'd0;
  logic [27:0] axi_araddr;
  logic [3:0]  axi_aruser_id;
  logic [3:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rlast = 1'b0;
  logic [3:0]  outstanding;
  logic        busy;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk_100M = ~clk_100M;

  ddr3_ar_issue #(.FIFO_LAT(2), .MAX_OUT(4)) dut (
    .clk_100M       (clk_100M),
    .rst_n          (rst_n),
    .enable         (enable),
    .araddr_empty   (araddr_empty),
    .araddr_ref     (araddr_ref),
    .fifo_araddr    (fifo_araddr),
    .fifo_aruser_id (fifo_aruser_id),
    .fifo_arlen     (fifo_arlen),
    .axi_araddr     (axi_araddr),
    .axi_aruser_id  (axi_aruser_id),
    .axi_arlen      (axi_arlen),
    .axi_arvalid    (axi_arvalid),
    .axi_arready    (axi_arready),
    .axi_rvalid     (axi_rvalid),
    .axi_rlast      (axi_rlast),
    .outstanding    (outstanding),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  // ---------------------------------------------------------------- FIFO model
  typedef struct packed {
    logic [3:0]  id;
    logic [27:0] addr;
    logic [3:0]  len;
  } cmd_t;

  cmd_t q[$];
  cmd_t s0, s1;
  bit   v0 = 1'b0, v1 = 1'b0;
  logic ref_q = 1'b0;
  int   pops = 0;
  int   pop_empty_cnt = 0;
  int   cyc = 0;
  int   last_pop = 0, prev_pop = 0;

  always @(posedge clk_100M) cyc <= cyc + 1;

  // Pops on the araddr_ref rising edge; data appears two cycles later,
  // garbage is shown in between so an early latch is visible.
  always @(negedge clk_100M) begin
    if (!rst_n) begin
      v0 = 1'b0;
      v1 = 1'b0;
      ref_q = 1'b0;
    end else begin
      if (v1) begin
        fifo_aruser_id = s1.id;
        fifo_araddr    = s1.addr;
        fifo_arlen     = s1.len;
        v1 = 1'b0;
      end
      if (v0) begin
        s1 = s0;
        v1 = 1'b1;
        v0 = 1'b0;
      end
      if (araddr_ref && !ref_q) begin
        pops++;
        prev_pop = last_pop;
        last_pop = cyc;
        if (q.size() == 0) begin
          pop_empty_cnt++;
        end else begin
          s0 = q.pop_front();
          v0 = 1'b1;
        end
        fifo_araddr    = 28'hBADBAD0;
        fifo_aruser_id = 4'hE;
        fifo_arlen     = 4'h9;
      end
      ref_q = araddr_ref;
    end
    araddr_empty = (q.size() == 0);
  end

  // ------------------------------------------------------------------ helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic wait_arvalid(input string name, input int lim);
    int n = 0;
    while (!axi_arvalid && n < lim) begin
      tick();
      n++;
    end
    chk(name, axi_arvalid, 1'b1);
  endtask

  task automatic wait_ref(input string name, input int lim);
    int n = 0;
    while (!araddr_ref && n < lim) begin
      tick();
      n++;
    end
    chk(name, araddr_ref, 1'b1);
  endtask

  task automatic push(input logic [3:0] id, input logic [27:0] addr, input logic [3:0] len);
    cmd_t c;
    c.id = id;
    c.addr = addr;
    c.len = len;
    q.push_back(c);
  endtask

  // Per-cycle vector: inputs applied before the edge, outputs checked after it
  typedef struct {
    logic       arready;
    logic       rvalid;
    logic       rlast;
    logic       ref_e;
    logic       arv_e;
    logic [3:0] out_e;
    logic       busy_e;
    logic       err_e;
  } vec_t;

  vec_t vt[8];
  int   p0;

  initial begin
    // T1 vectors: single command, arready tied high, then one completion
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0}; // POP
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // WAIT
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}; // LATCH
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0}; // ISSUE
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0}; // accepted
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0}; // idle, FIFO empty
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}; // RLAST
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}; // beat w/o last

    // Reset state
    repeat (3) tick();
    chk("rst_ref", araddr_ref, 1'b0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_araddr", axi_araddr, 28'd0);

    // T1
    enable = 1'b1;
    push(4'd1, 28'h0001230, 4'hF);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_arready = vt[i].arready;
      axi_rvalid  = vt[i].rvalid;
      axi_rlast   = vt[i].rlast;
      tick();
      chk($sformatf("t1_ref[%0d]", i), araddr_ref, vt[i].ref_e);
      chk($sformatf("t1_arvalid[%0d]", i), axi_arvalid, vt[i].arv_e);
      chk($sformatf("t1_outstanding[%0d]", i), outstanding, vt[i].out_e);
      chk($sformatf("t1_busy[%0d]", i), busy, vt[i].busy_e);
      chk($sformatf("t1_err[%0d]", i), err_underflow, vt[i].err_e);
      if (i == 3) begin
        chk("t1_araddr", axi_araddr, 28'h0001230);
        chk("t1_id", axi_aruser_id, 4'd1);
        chk("t1_len", axi_arlen, 4'hF);
      end
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("t1_pops", pops, 1);

    // T2: arready held low for 10 cycles in ISSUE
    axi_arready = 1'b0;
    push(4'd2, 28'h00ABCD0, 4'd3);
    wait_arvalid("t2_arvalid_timeout", 20);
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_arvalid_hold", axi_arvalid, 1'b1);
      chk("t2_addr_hold", axi_araddr, 28'h00ABCD0);
      chk("t2_id_hold", axi_aruser_id, 4'd2);
      chk("t2_len_hold", axi_arlen, 4'd3);
      chk("t2_no_pop", pops, p0);
    end
    axi_arready = 1'b1;
    tick();
    chk("t2_arvalid_clear", axi_arvalid, 1'b0);
    chk("t2_outstanding", outstanding, 4'd1);
    axi_rvalid = 1'b1;
    axi_rlast  = 1'b1;
    tick();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("t2_drain", outstanding, 4'd0);

    // T3: six commands, no completions -> throttled at MAX_OUT
    p0 = pops;
    for (int i = 0; i < 6; i++) push(4'(i + 8), 28'(32'h0100000 + i * 32'h100), 4'(i));
    repeat (50) tick();
    chk("t3_outstanding_max", outstanding, 4'd4);
    chk("t3_pops4", pops, p0 + 4);
    chk("t3_pop_interval", last_pop - prev_pop, 5);
    chk("t3_not_empty", araddr_empty, 1'b0);
    chk("t3_busy", busy, 1'b1);
    axi_rvalid = 1'b1;
    axi_rlast  = 1'b1;
    tick();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("t3_out_after_rlast", outstanding, 4'd3);
    chk("t3_no_same_cycle_pop", araddr_ref, 1'b0);
    tick();
    chk("t3_pop_next_cycle", araddr_ref, 1'b1);
    repeat (30) tick();
    chk("t3_outstanding_refill", outstanding, 4'd4);
    chk("t3_pops5", pops, p0 + 5);

    // T4: simultaneous accept and completion, then underflow
    enable = 1'b0;
    axi_arready = 1'b0;
    axi_rvalid = 1'b1;
    axi_rlast  = 1'b1;
    repeat (2) tick();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("t4_drain_to2", outstanding, 4'd2);
    enable = 1'b1;
    wait_arvalid("t4_arvalid_timeout", 20);
    enable = 1'b0;
    axi_arready = 1'b1;
    axi_rvalid = 1'b1;
    axi_rlast  = 1'b1;
    tick();
    chk("t4_both_same_cycle", outstanding, 4'd2);
    chk("t4_arvalid_clear", axi_arvalid, 1'b0);
    repeat (2) tick();
    chk("t4_drained", outstanding, 4'd0);
    chk("t4_no_err_yet", err_underflow, 1'b0);
    tick();
    chk("t4_underflow_err", err_underflow, 1'b1);
    chk("t4_underflow_sat", outstanding, 4'd0);
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    repeat (3) tick();
    chk("t4_err_sticky", err_underflow, 1'b1);

    // T5: reset in WAIT, then in ISSUE
    enable = 1'b1;
    axi_arready = 1'b1;
    push(4'd3, 28'h0055550, 4'd2);
    wait_ref("t5_ref_timeout", 20);
    tick();
    chk("t5_in_wait_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5w_ref", araddr_ref, 1'b0);
    chk("t5w_arvalid", axi_arvalid, 1'b0);
    chk("t5w_busy", busy, 1'b0);
    chk("t5w_err", err_underflow, 1'b0);
    chk("t5w_araddr", axi_araddr, 28'd0);
    chk("t5w_len", axi_arlen, 4'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_idle_after_release", busy, 1'b0);
    axi_arready = 1'b0;
    push(4'd5, 28'h0FFFFF0, 4'd7);
    wait_arvalid("t5_arvalid_timeout", 20);
    chk("t5_addr", axi_araddr, 28'h0FFFFF0);
    chk("t5_id", axi_aruser_id, 4'd5);
    chk("t5_len", axi_arlen, 4'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5i_arvalid", axi_arvalid, 1'b0);
    chk("t5i_araddr", axi_araddr, 28'd0);
    chk("t5i_id", axi_aruser_id, 4'd0);
    chk("t5i_outstanding", outstanding, 4'd0);
    chk("t5i_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // T6: enable dropped while in POP
    axi_arready = 1'b1;
    p0 = pops;
    push(4'd6, 28'h0000660, 4'd1);
    push(4'd7, 28'h0000770, 4'd2);
    wait_ref("t6_ref_timeout", 20);
    enable = 1'b0;
    wait_arvalid("t6_arvalid_timeout", 10);
    chk("t6_addr", axi_araddr, 28'h0000660);
    chk("t6_id", axi_aruser_id, 4'd6);
    tick();
    chk("t6_accepted", outstanding, 4'd1);
    chk("t6_arvalid_clear", axi_arvalid, 1'b0);
    repeat (20) tick();
    chk("t6_single_pop", pops, p0 + 1);
    chk("t6_fifo_not_empty", araddr_empty, 1'b0);
    chk("t6_busy", busy, 1'b1);
    axi_rvalid = 1'b1;
    axi_rlast  = 1'b1;
    tick();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("t6_idle", busy, 1'b0);

    chk("pop_on_empty", pop_empty_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
